// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the repeated-subtraction divider.
//   DEF_WIDTH : default operand / quotient / remainder width
//   state_t   : controller state encoding (IDLE, LDA, LDB, RUN, DONE)
package div_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/div_by_subtraction_if.sv
// div_by_subtraction_if: request/result bundle of the divider.
//   start, data_in                 : driven by the requester (master)
//   quotient, remainder, busy,
//   done, dbz                      : driven by the divider (slave)
// Handshake: the requester raises start while the divider is idle, then
// presents the dividend and the divisor on data_in on the next two cycles.
// Results are valid while done=1; done stays high until start is seen low.
interface div_by_subtraction_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             dbz;

  modport master (
    output start, data_in,
    input  quotient, remainder, busy, done, dbz
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, busy, done, dbz
  );

endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: controller FSM of the repeated-subtraction divider.
//   in : clk, rst_n (async, active-low), start, r_ge_d, d_eqz, q_sat
//   out: ld_r, ld_d, clr_q, sub_en, set_dbz (datapath strobes),
//        busy, done (Moore status), state (debug view of the FSM)
// Optional feature macro: DIV_ZERO_DETECT_EN enables the early exit on a
// zero divisor; without it d_eqz is ignored and set_dbz stays low.
module div_ctrl
  import div_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  logic   r_ge_d,
  input  logic   d_eqz,
  input  logic   q_sat,
  output logic   ld_r,
  output logic   ld_d,
  output logic   clr_q,
  output logic   sub_en,
  output logic   set_dbz,
  output logic   busy,
  output logic   done,
  output state_t state
);

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_r    = 1'b0;
    ld_d    = 1'b0;
    clr_q   = 1'b0;
    sub_en  = 1'b0;
    set_dbz = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LDA;
      LDA: begin
        ld_r    = 1'b1;
        state_d = LDB;
      end
      LDB: begin
        ld_d    = 1'b1;
        clr_q   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
`ifdef DIV_ZERO_DETECT_EN
        if (d_eqz) begin
          set_dbz = 1'b1;
          state_d = DONE;
        end else
`endif
        // Stopping at an all-ones quotient keeps Q from wrapping; this is
        // also what terminates a zero divisor when detection is absent.
        if (r_ge_d && !q_sat) sub_en  = 1'b1;
        else                  state_d = DONE;
      end
      DONE: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifndef DIV_ZERO_DETECT_EN
  logic unused_d_eqz;
  assign unused_d_eqz = d_eqz;
`endif

  assign busy  = (state_q == LDA) || (state_q == LDB) || (state_q == RUN);
  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

// File: rtl/div_by_subtraction.sv
// div_by_subtraction: unsigned divider by repeated subtraction.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : div_by_subtraction_if.slave (start, data_in in;
//                quotient, remainder, busy, done, dbz out)
//   dbg_state  : current controller state
// Optional feature macro: DIV_ZERO_DETECT_EN. When defined, a zero divisor
// finishes in one RUN cycle with dbz=1; when undefined, dbz is tied low and
// a zero divisor runs until the quotient saturates at all-ones.
module div_by_subtraction
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)(
  input  logic   clk,
  input  logic   rst_n,
  div_by_subtraction_if.slave bus,
  output state_t dbg_state
);

  logic [WIDTH-1:0] r_q, d_q, q_q;
  logic [WIDTH-1:0] diff;
  logic r_ge_d, d_eqz, q_sat;
  logic ld_r, ld_d, clr_q, sub_en, set_dbz;

  assign r_ge_d = (r_q >= d_q);
  assign d_eqz  = (d_q == '0);
  assign q_sat  = &q_q;
  // Only consumed under sub_en, which implies r_q >= d_q: never underflows.
  assign diff   = r_q - d_q;

  div_ctrl u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (bus.start),
    .r_ge_d  (r_ge_d),
    .d_eqz   (d_eqz),
    .q_sat   (q_sat),
    .ld_r    (ld_r),
    .ld_d    (ld_d),
    .clr_q   (clr_q),
    .sub_en  (sub_en),
    .set_dbz (set_dbz),
    .busy    (bus.busy),
    .done    (bus.done),
    .state   (dbg_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      d_q <= '0;
      q_q <= '0;
    end else begin
      if (ld_r) r_q <= bus.data_in;
      if (ld_d) d_q <= bus.data_in;
      if (clr_q) begin
        q_q <= '0;
      end else if (sub_en) begin
        r_q <= diff;
        q_q <= q_q + 1'b1;
      end else if (set_dbz) begin
        q_q <= '1;
      end
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dbz_q <= 1'b0;
    else if (ld_r)    dbz_q <= 1'b0;
    else if (set_dbz) dbz_q <= 1'b1;
  end
  assign bus.dbz = dbz_q;
`else
  logic unused_set_dbz;
  assign unused_set_dbz = set_dbz;
  assign bus.dbz = 1'b0;
`endif

  assign bus.quotient  = q_q;
  assign bus.remainder = r_q;

endmodule

// File: tb/tb_div_by_subtraction.sv
// tb_div_by_subtraction: self-checking bench for div_by_subtraction.
// A 16-bit instance carries the main scenarios; an 8-bit instance keeps the
// zero-divisor saturation run short when DIV_ZERO_DETECT_EN is undefined.
module tb_div_by_subtraction;
  import div_pkg::*;

  localparam int LIMIT16 = 70000;
  localparam int LIMIT8  = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_by_subtraction_if #(.WIDTH(16)) bus16 ();
  div_by_subtraction_if #(.WIDTH(8))  bus8 ();
  state_t st16, st8;

  div_by_subtraction #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus16), .dbg_state(st16)
  );
  div_by_subtraction #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .dbg_state(st8)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: plain arithmetic division with the zero-divisor rules.
  function automatic void model(input longint unsigned a, b, input int w,
                                output longint unsigned q, r,
                                output int lat, output bit dz);
    longint unsigned maxv = (64'd1 << w) - 1;
    if (b == 0) begin
      q = maxv;
      r = a;
`ifdef DIV_ZERO_DETECT_EN
      dz = 1'b1; lat = 3;
`else
      dz = 1'b0; lat = int'((64'd1 << w) + 2);
`endif
    end else begin
      q = a / b;
      r = a % b;
      dz = 1'b0;
      lat = int'(q) + 3;
    end
  endfunction

  // Runs one division on the 16-bit instance. lat counts edges from the
  // edge that samples start to the edge after which done is seen high.
  task automatic op16(input logic [15:0] a, b, input bit hold,
                      output logic [15:0] q, r, output logic dz,
                      output int lat, output int busy_cnt,
                      output logic done_after);
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.data_in = 16'($urandom);
    @(posedge clk); #1;
    bus16.start = hold ? 1'b1 : 1'($urandom_range(0, 1));
    lat = 0;
    busy_cnt = 0;
    while (!bus16.done && lat < LIMIT16) begin
      if (bus16.busy) busy_cnt++;
      if (lat == 0)      bus16.data_in = a;
      else if (lat == 1) bus16.data_in = b;
      else               bus16.data_in = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    q = bus16.quotient;
    r = bus16.remainder;
    dz = bus16.dbz;
    done_after = 1'b1;
    if (!hold) begin
      @(negedge clk);
      bus16.start = 1'b0;
      @(posedge clk); #1;
      done_after = bus16.done;
    end
  endtask

  task automatic op8(input logic [7:0] a, b,
                     output logic [7:0] q, r, output logic dz, output int lat);
    @(negedge clk);
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0;
    while (!bus8.done && lat < LIMIT8) begin
      bus8.data_in = (lat == 0) ? a : (lat == 1) ? b : 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    q = bus8.quotient;
    r = bus8.remainder;
    dz = bus8.dbz;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus16.quotient, bus16.remainder} !== 32'd0) begin
      errors++; $display("FAIL reset_qr got %h want 0", {bus16.quotient, bus16.remainder});
    end
    checks++;
    if ({bus16.busy, bus16.done, bus16.dbz} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {bus16.busy, bus16.done, bus16.dbz});
    end
    checks++;
    if (st16 !== IDLE) begin
      errors++; $display("FAIL reset_state got %0d want %0d", st16, IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Directed table: typical, dividend < divisor, zero dividend, and the
  // largest quotient that must not be cut short by the saturation guard.
  task automatic test_directed();
    logic [15:0] ta [4] = '{16'd17, 16'd4, 16'd0, 16'd65535};
    logic [15:0] tb [4] = '{16'd5,  16'd9, 16'd7, 16'd1};
    for (int i = 0; i < 4; i++) begin
      logic [15:0] q, r; logic dz, da; int lat, bc, elat;
      longint unsigned mq, mr; bit mdz; logic [31:0] e;
      model(ta[i], tb[i], 16, mq, mr, elat, mdz);
      exp_q.push_back({mq[15:0], mr[15:0]});
      op16(ta[i], tb[i], 1'b0, q, r, dz, lat, bc, da);
      e = exp_q.pop_front();
      checks++;
      if ({q, r} !== e) begin
        errors++; $display("FAIL dir_qr[%0d] got q=%0d r=%0d want q=%0d r=%0d", i, q, r, e[31:16], e[15:0]);
      end
      checks++;
      if (lat !== elat) begin
        errors++; $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, elat);
      end
      checks++;
      if (bc !== elat) begin
        errors++; $display("FAIL dir_busy_cycles[%0d] got %0d want %0d", i, bc, elat);
      end
      checks++;
      if (dz !== 1'b0) begin
        errors++; $display("FAIL dir_dbz[%0d] got %b want 0", i, dz);
      end
      checks++;
      if (da !== 1'b0) begin
        errors++; $display("FAIL dir_done_fall[%0d] got %b want 0", i, da);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [15:0] a, b, q, r; logic dz, da; int lat, bc, elat;
      longint unsigned mq, mr; bit mdz; logic [31:0] e;
      a = 16'($urandom_range(0, 4095));
      b = 16'($urandom_range(16, 1023));
      model(a, b, 16, mq, mr, elat, mdz);
      exp_q.push_back({mq[15:0], mr[15:0]});
      op16(a, b, 1'b0, q, r, dz, lat, bc, da);
      e = exp_q.pop_front();
      checks++;
      if ({q, r} !== e || lat !== elat || dz !== mdz) begin
        errors++;
        $display("FAIL rand[%0d] %0d/%0d got q=%0d r=%0d lat=%0d dbz=%b want q=%0d r=%0d lat=%0d dbz=%b",
                 i, a, b, q, r, lat, dz, e[31:16], e[15:0], elat, mdz);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q8, r8; logic dz8; int lat8, elat;
    longint unsigned mq, mr; bit mdz;
    model(100, 0, 8, mq, mr, elat, mdz);
    op8(8'd100, 8'd0, q8, r8, dz8, lat8);
    checks++;
    if ({q8, r8, dz8} !== {mq[7:0], mr[7:0], mdz}) begin
      errors++; $display("FAIL dz8_result got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                         q8, r8, dz8, mq[7:0], mr[7:0], mdz);
    end
    checks++;
    if (lat8 !== elat) begin
      errors++; $display("FAIL dz8_latency got %0d want %0d", lat8, elat);
    end
`ifdef DIV_ZERO_DETECT_EN
    begin
      logic [15:0] q, r; logic dz, da; int lat, bc;
      model(100, 0, 16, mq, mr, elat, mdz);
      op16(16'd100, 16'd0, 1'b0, q, r, dz, lat, bc, da);
      checks++;
      if ({q, r, dz} !== {mq[15:0], mr[15:0], mdz} || lat !== elat) begin
        errors++; $display("FAIL dz16 got q=%h r=%0d dbz=%b lat=%0d want q=%h r=%0d dbz=%b lat=%0d",
                           q, r, dz, lat, mq[15:0], mr[15:0], mdz, elat);
      end
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] q, r; logic dz, da; int lat, bc;
    op16(16'd21, 16'd4, 1'b1, q, r, dz, lat, bc, da);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus16.done !== 1'b1 || bus16.busy !== 1'b0 || st16 !== DONE) begin
      errors++; $display("FAIL hold_done got done=%b busy=%b state=%0d want 1 0 %0d",
                         bus16.done, bus16.busy, st16, DONE);
    end
    checks++;
    if ({bus16.quotient, bus16.remainder} !== {16'd5, 16'd1}) begin
      errors++; $display("FAIL hold_qr got q=%0d r=%0d want q=5 r=1", bus16.quotient, bus16.remainder);
    end
    @(negedge clk);
    bus16.start = 1'b0;
    op16(16'd30, 16'd7, 1'b0, q, r, dz, lat, bc, da);
    checks++;
    if ({q, r} !== {16'd4, 16'd2} || lat !== 7 || dz !== 1'b0) begin
      errors++; $display("FAIL restart got q=%0d r=%0d lat=%0d dbz=%b want q=4 r=2 lat=7 dbz=0", q, r, lat, dz);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus16.data_in = 16'd1000;
    @(posedge clk); #1;
    bus16.data_in = 16'd3;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus16.quotient, bus16.remainder, bus16.busy, bus16.done, bus16.dbz} !== 35'd0) begin
      errors++; $display("FAIL midrst_outputs got q=%0d r=%0d busy=%b done=%b dbz=%b want all 0",
                         bus16.quotient, bus16.remainder, bus16.busy, bus16.done, bus16.dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (st16 !== IDLE || bus16.done !== 1'b0 || bus16.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got state=%0d done=%b busy=%b want %0d 0 0",
                         st16, bus16.done, bus16.busy, IDLE);
    end
  endtask

  initial begin
    bus16.start = 1'b0; bus16.data_in = '0;
    bus8.start = 1'b0;  bus8.data_in = '0;
    test_reset();
    test_directed();
    test_random();
    test_div_zero();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
